// File: rtl/exec_alu_unit.sv
// Execute stage of the MIPS-lite core: ALU control decode, 32-bit ALU with flags,
// PC+4 / branch-target adders and a V/Z/N status register. Define ALU_NOR_EN to enable NOR.
module exec_alu_unit #(
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        aluop1,
  input  logic        aluop0,
  input  logic [3:0]  funct,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flag_en,
  input  logic [31:0] pc,
  input  logic [15:0] offset,
  output logic [2:0]  gout,
  output logic [31:0] alu_result,
  output logic        zout,
  output logic        vout,
  output logic        nout,
  output logic        v_flag,
  output logic        z_flag,
  output logic        n_flag,
  output logic [31:0] pc_plus4,
  output logic [31:0] branch_target
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
  localparam logic [2:0] OP_NOR = 3'b100;

  logic [31:0] sum;
  logic [31:0] diff;
  logic        add_ovf;
  logic        sub_ovf;
  logic        less;

  always_comb begin
    gout = OP_ADD;
    unique case ({aluop1, aluop0})
      2'b00: gout = OP_ADD;
      2'b01: gout = OP_SUB;
      2'b11: gout = OP_OR;
      2'b10: begin
        case (funct)
          4'b0000: gout = OP_ADD;
          4'b0010: gout = OP_SUB;
          4'b0100: gout = OP_AND;
          4'b0101: gout = OP_OR;
          4'b1010: gout = OP_SLT;
`ifdef ALU_NOR_EN
          4'b0111: gout = OP_NOR;
`endif
          default: gout = OP_ADD;
        endcase
      end
      default: gout = OP_ADD;
    endcase
  end

  assign sum     = a + b;
  assign diff    = a - b;
  assign add_ovf = (a[31] == b[31]) && (sum[31] != a[31]);
  assign sub_ovf = (a[31] != b[31]) && (diff[31] != a[31]);
  // Signed less-than from the subtraction stays correct when a - b overflows.
  assign less    = diff[31] ^ sub_ovf;

  always_comb begin
    alu_result = 32'd0;
    vout       = 1'b0;
    case (gout)
      OP_AND: alu_result = a & b;
      OP_OR:  alu_result = a | b;
      OP_ADD: begin
        alu_result = sum;
        vout       = add_ovf;
      end
      OP_SUB: begin
        alu_result = diff;
        vout       = sub_ovf;
      end
      OP_SLT: alu_result = {31'd0, less};
`ifdef ALU_NOR_EN
      OP_NOR: alu_result = ~(a | b);
`endif
      default: alu_result = 32'd0;
    endcase
  end

  assign zout = (alu_result == 32'd0);
  assign nout = alu_result[31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_flag <= 1'b0;
      z_flag <= 1'b0;
      n_flag <= 1'b0;
    end else if (flag_en) begin
      v_flag <= vout;
      z_flag <= zout;
      n_flag <= nout;
    end
  end

  assign pc_plus4      = pc + PC_STEP;
  assign branch_target = pc_plus4 + {{14{offset[15]}}, offset, 2'b00};

endmodule

// File: tb/tb_exec_alu_unit.sv
// Table-driven self-checking bench for exec_alu_unit, with directed sequences
// for the status register's reset and hold behaviour.
module tb_exec_alu_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        aluop1, aluop0;
  logic [3:0]  funct;
  logic [31:0] a, b;
  logic        flag_en;
  logic [31:0] pc;
  logic [15:0] offset;
  logic [2:0]  gout;
  logic [31:0] alu_result;
  logic        zout, vout, nout;
  logic        v_flag, z_flag, n_flag;
  logic [31:0] pc_plus4, branch_target;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  aluop;
    logic [3:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [15:0] offset;
    logic [2:0]  exp_g;
    logic [31:0] exp_res;
    logic        exp_z;
    logic        exp_v;
    logic        exp_n;
    logic [31:0] exp_pc4;
    logic [31:0] exp_bt;
  } vec_t;

  vec_t vecs[$];

  exec_alu_unit dut (
    .clk(clk), .rst_n(rst_n), .aluop1(aluop1), .aluop0(aluop0), .funct(funct),
    .a(a), .b(b), .flag_en(flag_en), .pc(pc), .offset(offset), .gout(gout),
    .alu_result(alu_result), .zout(zout), .vout(vout), .nout(nout),
    .v_flag(v_flag), .z_flag(z_flag), .n_flag(n_flag),
    .pc_plus4(pc_plus4), .branch_target(branch_target)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic [1:0] op, logic [3:0] f, logic [31:0] va, logic [31:0] vb,
                              logic [31:0] vpc, logic [15:0] voff, logic [2:0] g, logic [31:0] r,
                              logic z, logic v, logic n, logic [31:0] p4, logic [31:0] bt);
    vec_t t;
    t.aluop = op; t.funct = f; t.a = va; t.b = vb; t.pc = vpc; t.offset = voff;
    t.exp_g = g; t.exp_res = r; t.exp_z = z; t.exp_v = v; t.exp_n = n;
    t.exp_pc4 = p4; t.exp_bt = bt;
    return t;
  endfunction

  task automatic applyStimulus(input vec_t t, input logic en);
    {aluop1, aluop0} = t.aluop;
    funct   = t.funct;
    a       = t.a;
    b       = t.b;
    pc      = t.pc;
    offset  = t.offset;
    flag_en = en;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkComb(input vec_t t, input int idx);
    checkOutput($sformatf("gout[%0d]", idx), {29'd0, gout}, {29'd0, t.exp_g});
    checkOutput($sformatf("result[%0d]", idx), alu_result, t.exp_res);
    checkOutput($sformatf("zvn[%0d]", idx), {29'd0, zout, vout, nout}, {29'd0, t.exp_z, t.exp_v, t.exp_n});
    checkOutput($sformatf("pc_plus4[%0d]", idx), pc_plus4, t.exp_pc4);
    checkOutput($sformatf("branch_target[%0d]", idx), branch_target, t.exp_bt);
  endtask

  task automatic checkFlags(input string name, input logic v, input logic z, input logic n);
    checkOutput(name, {29'd0, v_flag, z_flag, n_flag}, {29'd0, v, z, n});
  endtask

  initial begin
    vec_t ovf, subeq;

    vecs.push_back(mk(2'b10, 4'b0000, 32'h7FFFFFFF, 32'h1, 32'h10, 16'hFFFE, 3'b010, 32'h80000000, 0, 1, 1, 32'h14, 32'h0C));
    vecs.push_back(mk(2'b01, 4'b0000, 32'h12345678, 32'h12345678, 32'hFFFFFFFC, 16'h0000, 3'b110, 32'h0, 1, 0, 0, 32'h0, 32'h0));
    vecs.push_back(mk(2'b01, 4'b0000, 32'h80000000, 32'h1, 32'h0, 16'h7FFF, 3'b110, 32'h7FFFFFFF, 0, 1, 0, 32'h4, 32'h20000));
    vecs.push_back(mk(2'b10, 4'b1010, 32'hFFFFFFFF, 32'h1, 32'h1000, 16'h0001, 3'b111, 32'h1, 0, 0, 0, 32'h1004, 32'h1008));
    vecs.push_back(mk(2'b10, 4'b1010, 32'h80000000, 32'h7FFFFFFF, 32'h0, 16'h0, 3'b111, 32'h1, 0, 0, 0, 32'h4, 32'h4));
    vecs.push_back(mk(2'b10, 4'b1010, 32'h7FFFFFFF, 32'h80000000, 32'h0, 16'h0, 3'b111, 32'h0, 1, 0, 0, 32'h4, 32'h4));
    vecs.push_back(mk(2'b10, 4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 16'h0, 3'b000, 32'hF000F000, 0, 0, 1, 32'h4, 32'h4));
    vecs.push_back(mk(2'b10, 4'b0101, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 16'h0, 3'b001, 32'hFFF0FFF0, 0, 0, 1, 32'h4, 32'h4));
    vecs.push_back(mk(2'b11, 4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 16'h0, 3'b001, 32'hFFF0FFF0, 0, 0, 1, 32'h4, 32'h4));
`ifdef ALU_NOR_EN
    vecs.push_back(mk(2'b10, 4'b0111, 32'h0, 32'h0, 32'h0, 16'h0, 3'b100, 32'hFFFFFFFF, 0, 0, 1, 32'h4, 32'h4));
`else
    vecs.push_back(mk(2'b10, 4'b0111, 32'h0, 32'h0, 32'h0, 16'h0, 3'b010, 32'h0, 1, 0, 0, 32'h4, 32'h4));
`endif
    vecs.push_back(mk(2'b00, 4'b1010, 32'h5, 32'h3, 32'h0, 16'h0, 3'b010, 32'h8, 0, 0, 0, 32'h4, 32'h4));
    vecs.push_back(mk(2'b10, 4'b0010, 32'h3, 32'h5, 32'h0, 16'h0, 3'b110, 32'hFFFFFFFE, 0, 0, 1, 32'h4, 32'h4));
    vecs.push_back(mk(2'b10, 4'b1111, 32'h2, 32'h2, 32'h0, 16'h0, 3'b010, 32'h4, 0, 0, 0, 32'h4, 32'h4));
    vecs.push_back(mk(2'b00, 4'b0000, 32'h80000000, 32'h80000000, 32'h0, 16'h0, 3'b010, 32'h0, 1, 1, 0, 32'h4, 32'h4));
    ovf   = vecs[0];
    subeq = vecs[1];

    rst_n = 1'b0;
    applyStimulus(ovf, 1'b1);
    repeat (2) @(posedge clk);
    #1 checkFlags("reset_flags", 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;

    // Each vector is captured at the next edge and must show up on the registered flags.
    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i], 1'b1);
      #1 checkComb(vecs[i], i);
      @(posedge clk);
      #1 checkFlags($sformatf("flags[%0d]", i), vecs[i].exp_v, vecs[i].exp_z, vecs[i].exp_n);
    end

    @(negedge clk) applyStimulus(ovf, 1'b1);
    @(posedge clk);
    #1 checkFlags("ovf_capture", 1, 0, 1);
    #2 rst_n = 1'b0;
    #1 checkFlags("async_reset", 0, 0, 0);
    checkOutput("result_during_reset", alu_result, 32'h80000000);

    @(negedge clk) begin
      rst_n = 1'b1;
      applyStimulus(ovf, 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 checkFlags($sformatf("hold_%0d", k), 0, 0, 0);
      @(negedge clk) applyStimulus((k % 2 == 0) ? subeq : ovf, 1'b0);
    end

    @(negedge clk) rst_n = 1'b0;
    #2 begin
      rst_n = 1'b1;
      applyStimulus(subeq, 1'b1);
    end
    @(posedge clk);
    #1 checkFlags("first_edge_after_reset", 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exec_alu_unit.md
Name: exec_alu_unit

Overview:
- Execute-stage datapath block of the single-cycle MIPS-lite processor. Contains the ALU control decoder, the 32-bit ALU with zero/overflow/negative flags, and the PC+4 and branch-target adders.
- Also holds a clocked status register (V/Z/N) that captures ALU flags for the flag-conditioned branches (balrnv, baln).
- All datapath outputs are combinational. Only the status flags are registered.

Parameters:
- PC_STEP, 4, constant added to pc to form pc_plus4.

Ports:
- clk  in  1  system clock; status register samples on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- aluop1  in  1  ALU op class, high bit.
- aluop0  in  1  ALU op class, low bit.
- funct  in  4  instruction bits [3:0].
- a  in  32  ALU operand A (readdata1).
- b  in  32  ALU operand B (ALUSrc mux output).
- flag_en  in  1  capture ALU flags into the status register this cycle.
- pc  in  32  current program counter.
- offset  in  16  instruction bits [15:0], the branch offset.
- gout  out  3  decoded ALU operation.
- alu_result  out  32  ALU result.
- zout  out  1  combinational zero flag.
- vout  out  1  combinational overflow flag.
- nout  out  1  combinational negative flag.
- v_flag  out  1  registered overflow flag.
- z_flag  out  1  registered zero flag.
- n_flag  out  1  registered negative flag.
- pc_plus4  out  32  pc + PC_STEP.
- branch_target  out  32  pc_plus4 + (sign-extended offset << 2).

Behaviour:
- ALU control decode ({aluop1,aluop0}):
  - 00 -> ADD (gout 010).
  - 01 -> SUB (110).
  - 11 -> OR (001), used by ori.
  - 10 -> R-type, decoded on funct: 0000 ADD 010; 0010 SUB 110; 0100 AND 000; 0101 OR 001; 1010 SLT 111; 0111 NOR 100 (see optional feature).
  - Any other funct under 10 -> ADD 010.
- ALU operations by gout:
  - 000: a & b.
  - 001: a | b.
  - 010: a + b, mod 2^32.
  - 110: a - b, mod 2^32.
  - 111: 32'd1 if a < b signed, else 0. The comparison is computed from subtraction sign XOR subtraction overflow, so it is correct at extremes.
  - 100: ~(a | b).
  - Unused codes (011, 101): result 0.
- Combinational flags:
  - zout = (alu_result == 0).
  - nout = alu_result[31].
  - vout for ADD = a[31]==b[31] && result[31]!=a[31].
  - vout for SUB = a[31]!=b[31] && result[31]!=a[31].
  - vout = 0 for all other ops.
- Status register:
  - rst_n low asynchronously clears v_flag, z_flag, n_flag to 0, independent of clk.
  - On a rising edge of clk with rst_n high and flag_en=1, loads {vout,zout,nout}.
  - With flag_en=0 the flags hold their value.
  - Latency 1 cycle: registered flags reflect the operation from the previous enabled cycle.
  - Reset asserted mid-cycle clears the flags immediately. The first edge after rst_n deasserts captures normally.
- Adders:
  - pc_plus4 = pc + PC_STEP, wraps mod 2^32 (0xFFFFFFFC -> 0x00000000).
  - branch_target = pc_plus4 + ({{14{offset[15]}},offset,2'b00}), wraps mod 2^32.
- The combinational outputs (gout, alu_result, zout, vout, nout, pc_plus4, branch_target) are unaffected by rst_n.

Optional Feature:
- ALU_NOR_EN defined: funct 0111 under aluop 10 decodes to gout 100 and the ALU performs NOR.
- ALU_NOR_EN undefined: funct 0111 decodes as ADD (010), and gout 100 yields result 0 with vout=0.

Test Plan:
- Add overflow: aluop=10, funct=0000, a=0x7FFFFFFF, b=1 -> gout 010, alu_result 0x80000000, vout=1, nout=1, zout=0. With flag_en=1, after the next rising edge v_flag=1, n_flag=1, z_flag=0.
- Sub equal operands: aluop=01, a=b=0x12345678 -> gout 110, result 0, zout=1, vout=0. Then a=0x80000000, b=1 -> result 0x7FFFFFFF, vout=1.
- SLT/logic: funct 1010, a=0xFFFFFFFF, b=1 -> result 1. funct 0100 on 0xF0F0F0F0 and 0xFF00FF00 -> 0xF000F000. funct 0101 on the same operands -> 0xFFF0FFF0. aluop=11 -> OR result 0xFFF0FFF0.
- NOR: funct 0111, a=0, b=0 -> result 0xFFFFFFFF with ALU_NOR_EN defined. Without the macro the result is 0 (ADD).
- Adders: pc=0x00000010, offset=0xFFFE -> pc_plus4 0x14, branch_target 0x0C. pc=0xFFFFFFFC -> pc_plus4 0x00000000.
- Reset and hold:
  - Flags set to 1, then rst_n=0 between clock edges -> all flags 0 immediately.
  - After release, flag_en=0 for 3 edges -> flags stay 0 regardless of ALU activity.
